mem_arbiter_mp: RTL and testbench

- Parametrised multi-port memory controller, successor to the fixed core/VGA/input controller.
- Arbitrates NUM_PORTS requester ports plus one reserved VGA read slot onto a single synchronous-RAM port.
- Decodes a memory-mapped IO region (address MSB = 1) onto a strobed IO bus.
- Sits between the CPU core, input and DMA masters, the VGA scanout, the block RAM and the IO peripherals.

---
 rtl/mem_arbiter_pkg.sv | 22 ++
 rtl/mem_arbiter_mp_if.sv | 20 ++
 rtl/mem_arbiter_mp_rr_arbiter.sv | 49 ++++
 rtl/mem_arbiter_mp.sv | 196 +++++++++++++++++++
 tb/tb_mem_arbiter_mp.sv | 279 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and helpers for the multi-port memory arbiter.
//   src_e      : response source tag carried down the response pipe
//   io_sel_bit : address bit index that selects the IO region
//   idx_w      : width of a port index (at least 1 bit)
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    SRC_RAM  = 2'd0,
    SRC_IO   = 2'd1,
    SRC_ZERO = 2'd2,
    SRC_VGA  = 2'd3
  } src_e;

  function automatic int io_sel_bit(input int addr_w);
    return addr_w - 1;
  endfunction

  function automatic int idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_arbiter_mp_if.sv
// Requester bus of the multi-port memory arbiter.
//   master : requester side (drives req/we/addr/wdata, receives gnt/rvalid/rdata)
//   slave  : arbiter side
// addr/wdata are flat-packed, port p at [p*W +: W].
interface mem_arbiter_mp_if #(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 16
);
  logic [NUM_PORTS-1:0]        req;
  logic [NUM_PORTS-1:0]        we;
  logic [NUM_PORTS*ADDR_W-1:0] addr;
  logic [NUM_PORTS*DATA_W-1:0] wdata;
  logic [NUM_PORTS-1:0]        gnt;
  logic [NUM_PORTS-1:0]        rvalid;
  logic [DATA_W-1:0]           rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/mem_arbiter_mp_rr_arbiter.sv
// Round-robin arbiter with hold-off.
//   clk, reset : clock, synchronous active-low reset
//   hold_i     : suppress any grant this cycle (pointer frozen)
//   req_i      : per-port requests
//   gnt_o      : one-hot grant (combinational)
//   idx_o      : index of the granted port
//   vld_o      : a grant was issued
// Pointer holds the last granted port; the scan starts one above it.
module rr_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  localparam int IW = idx_w(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 hold_i,
  input  logic [NUM_PORTS-1:0] req_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [IW-1:0]        idx_o,
  output logic                 vld_o
);

  logic [IW-1:0] ptr_q, ptr_d;

  always_comb begin
    int p;
    gnt_o = '0;
    idx_o = '0;
    vld_o = 1'b0;
    p     = 0;
    for (int i = 1; i <= NUM_PORTS; i++) begin
      p = (int'(ptr_q) + i) % NUM_PORTS;
      if (!hold_i && !vld_o && req_i[p]) begin
        gnt_o[p] = 1'b1;
        idx_o    = IW'(p);
        vld_o    = 1'b1;
      end
    end
    ptr_d = vld_o ? idx_o : ptr_q;
  end

  // Resetting to the top port makes port 0 the first winner.
  always_ff @(posedge clk) begin
    if (!reset) ptr_q <= IW'(NUM_PORTS - 1);
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem_arbiter_mp.sv
// Multi-port memory arbiter: NUM_PORTS requesters plus a reserved VGA read
// slot onto one synchronous RAM port, with an IO region (addr MSB = 1).
//   clk, reset              : clock, synchronous active-low reset
//   enable                  : allow new issues
//   pixel_state, vga_addr   : VGA slot phase and word address
//   vga_data_out, vga_valid : last VGA word and its update strobe
//   bus (slave)             : requester req/we/addr/wdata, gnt/rvalid/rdata
//   ram_*                   : RAM command, ram_rdata valid one cycle after ram_en
//   io_*                    : single-cycle IO strobes, io_rdata sampled with io_rd
// Pipeline: T decide/grant, T+1 command, T+2 response.
module mem_arbiter_mp
  import mem_arbiter_pkg::*;
#(
  parameter int          ADDR_W    = 24,
  parameter int          DATA_W    = 16,
  parameter int          NUM_PORTS = 2,
  parameter int          RAM_AW    = 15,
  parameter int          VGA_AW    = 15,
  parameter int          VGA_BASE  = 0,
  parameter logic [1:0]  VGA_SLOT  = 2'd0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [1:0]        pixel_state,
  input  logic [VGA_AW-1:0] vga_addr,
  output logic [DATA_W-1:0] vga_data_out,
  output logic              vga_valid,
  mem_arbiter_mp_if.slave   bus,
  output logic              ram_en,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              io_wr,
  output logic              io_rd,
  output logic [ADDR_W-2:0] io_addr,
  output logic [DATA_W-1:0] io_wdata,
  input  logic [DATA_W-1:0] io_rdata
);

  localparam int IW     = idx_w(NUM_PORTS);
  localparam int IO_BIT = io_sel_bit(ADDR_W);

  logic              vga_slot, vga_issue, hold, gvld;
  logic [IW-1:0]     gidx;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_we, sel_io, sel_oor;

  assign vga_slot  = (pixel_state == VGA_SLOT);
  assign vga_issue = reset && enable && vga_slot;
  // Reset also gates the grant so gnt reads 0 while reset is held.
  assign hold      = !reset || !enable || vga_slot;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr (
    .clk    (clk),
    .reset  (reset),
    .hold_i (hold),
    .req_i  (bus.req),
    .gnt_o  (bus.gnt),
    .idx_o  (gidx),
    .vld_o  (gvld)
  );

  assign sel_addr  = bus.addr[int'(gidx)*ADDR_W +: ADDR_W];
  assign sel_wdata = bus.wdata[int'(gidx)*DATA_W +: DATA_W];
  assign sel_we    = bus.we[gidx];
  assign sel_io    = sel_addr[IO_BIT];
  // RAM space with any bit between RAM_AW and the IO bit set maps to nothing.
  assign sel_oor   = !sel_io &&
                     (((sel_addr & ~(ADDR_W'(1) << IO_BIT)) >> RAM_AW) != '0);

  // Command stage registers and the response tag pipe.
  logic              ram_en_q, ram_en_d, ram_we_q, ram_we_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
  logic              io_wr_q, io_wr_d, io_rd_q, io_rd_d;
  logic [ADDR_W-2:0] io_addr_q, io_addr_d;
  logic [DATA_W-1:0] io_wdata_q, io_wdata_d;
  logic              vld_d;
  src_e              src_d;
  logic [IW-1:0]     port_d;
  logic [2:1]        vld_pipe_q;
  src_e              src_q  [2:1];
  logic [IW-1:0]     port_q [2:1];
  logic [DATA_W-1:0] io_cap_q, vga_hold_q;

  always_comb begin
    ram_en_d    = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    io_wr_d     = 1'b0;
    io_rd_d     = 1'b0;
    io_addr_d   = io_addr_q;
    io_wdata_d  = io_wdata_q;
    vld_d       = 1'b0;
    src_d       = SRC_ZERO;
    port_d      = gidx;
    if (vga_issue) begin
      ram_en_d   = 1'b1;
      ram_addr_d = RAM_AW'(vga_addr) + RAM_AW'(VGA_BASE);
      vld_d      = 1'b1;
      src_d      = SRC_VGA;
    end else if (gvld) begin
      // Only reads carry a tag; an out-of-range read answers with zero.
      vld_d = !sel_we;
      if (sel_io) begin
        io_wr_d    = sel_we;
        io_rd_d    = !sel_we;
        io_addr_d  = sel_addr[IO_BIT-1:0];
        io_wdata_d = sel_wdata;
        src_d      = SRC_IO;
      end else if (!sel_oor) begin
        ram_en_d    = 1'b1;
        ram_we_d    = sel_we;
        ram_addr_d  = sel_addr[RAM_AW-1:0];
        ram_wdata_d = sel_wdata;
        src_d       = SRC_RAM;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ram_en_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      io_wr_q     <= 1'b0;
      io_rd_q     <= 1'b0;
      io_addr_q   <= '0;
      io_wdata_q  <= '0;
      vld_pipe_q  <= '0;
      src_q[1]    <= SRC_ZERO;
      src_q[2]    <= SRC_ZERO;
      port_q[1]   <= '0;
      port_q[2]   <= '0;
      io_cap_q    <= '0;
      vga_hold_q  <= '0;
    end else begin
      ram_en_q      <= ram_en_d;
      ram_we_q      <= ram_we_d;
      ram_addr_q    <= ram_addr_d;
      ram_wdata_q   <= ram_wdata_d;
      io_wr_q       <= io_wr_d;
      io_rd_q       <= io_rd_d;
      io_addr_q     <= io_addr_d;
      io_wdata_q    <= io_wdata_d;
      vld_pipe_q[1] <= vld_d;
      src_q[1]      <= src_d;
      port_q[1]     <= port_d;
      vld_pipe_q[2] <= vld_pipe_q[1];
      src_q[2]      <= src_q[1];
      port_q[2]     <= port_q[1];
      if (io_rd_q)   io_cap_q   <= io_rdata;
      if (vga_valid) vga_hold_q <= ram_rdata;
    end
  end

  assign ram_en    = ram_en_q;
  assign ram_we    = ram_we_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign io_wr     = io_wr_q;
  assign io_rd     = io_rd_q;
  assign io_addr   = io_addr_q;
  assign io_wdata  = io_wdata_q;

  // Response stage: VGA word passes straight through and is held afterwards.
  logic                 rsp_vld;
  logic [NUM_PORTS-1:0] rvalid_c;
  logic [DATA_W-1:0]    rdata_c;

  assign vga_valid    = vld_pipe_q[2] && (src_q[2] == SRC_VGA);
  assign rsp_vld      = vld_pipe_q[2] && (src_q[2] != SRC_VGA);
  assign vga_data_out = vga_valid ? ram_rdata : vga_hold_q;

  always_comb begin
    rvalid_c = '0;
    rdata_c  = '0;
    if (rsp_vld) begin
      rvalid_c[port_q[2]] = 1'b1;
      case (src_q[2])
        SRC_RAM: rdata_c = ram_rdata;
        SRC_IO:  rdata_c = io_cap_q;
        default: rdata_c = '0;
      endcase
    end
  end

  assign bus.rvalid = rvalid_c;
  assign bus.rdata  = rdata_c;

endmodule

// File: tb/tb_mem_arbiter_mp.sv
module tb_mem_arbiter_mp;
  localparam int NP = 2, AW = 24, DW = 16, RAW = 15, VAW = 15, VBASE = 0;
  localparam logic [1:0] SLOT = 2'd0;

  logic clk = 1'b0;
  logic reset, enable, preload;
  logic [1:0]     pixel_state;
  logic [VAW-1:0] vga_addr;
  logic [DW-1:0]  vga_data_out, ram_wdata, ram_rdata, io_wdata, io_rdata;
  logic           vga_valid, ram_en, ram_we, io_wr, io_rd;
  logic [RAW-1:0] ram_addr;
  logic [AW-2:0]  io_addr;

  mem_arbiter_mp_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_arbiter_mp #(.ADDR_W(AW), .DATA_W(DW), .NUM_PORTS(NP), .RAM_AW(RAW),
                   .VGA_AW(VAW), .VGA_BASE(VBASE), .VGA_SLOT(SLOT)) dut (
    .clk(clk), .reset(reset), .enable(enable), .pixel_state(pixel_state),
    .vga_addr(vga_addr), .vga_data_out(vga_data_out), .vga_valid(vga_valid),
    .bus(bus), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .io_wr(io_wr), .io_rd(io_rd),
    .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata));

  always #5 clk = ~clk;

  // Synchronous RAM device; only words 0..127 are ever touched.
  logic [DW-1:0] ram [0:(1<<RAW)-1];
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 128; i++) ram[i] <= (i == 100) ? 16'h00FF : 16'h0000;
    end else if (ram_en) begin
      if (ram_we) ram[ram_addr] <= ram_wdata;
      else        ram_rdata     <= ram[ram_addr];
    end
  end

  // IO device: read data is a fixed function of the offset.
  function automatic logic [DW-1:0] io_fn(input logic [AW-2:0] a);
    if (a == 23'd19968) return 16'h1234;
    return {a[7:0] ^ 8'h5A, a[15:8]};
  endfunction
  assign io_rdata = io_fn(io_addr);

  // Reference model: one decided operation per cycle, aged through two slots.
  typedef struct packed {
    bit ram_en; bit ram_we; logic [RAW-1:0] raddr; logic [DW-1:0] rwd;
    bit iow; bit ior; logic [AW-2:0] ioaddr; logic [DW-1:0] iowd;
    bit rsp; logic [7:0] port; bit vga; logic [DW-1:0] data;
  } op_t;

  op_t           dec, s1, s2;
  logic [NP-1:0] exp_gnt;
  int            ptr;
  bit            cur_rst;
  logic [DW-1:0] shadow [0:127];
  logic [DW-1:0] vga_last;
  int            pass_cnt = 0, total_cnt = 0;

  function automatic logic [NP*AW-1:0] pa(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    return {a1, a0};
  endfunction

  task automatic drive(input bit rst, input bit en, input logic [1:0] ps,
                       input logic [NP-1:0] rq, input logic [NP-1:0] wv,
                       input logic [NP*AW-1:0] ad, input logic [NP*DW-1:0] wd);
    reset = rst; enable = en; pixel_state = ps;
    bus.req = rq; bus.we = wv; bus.addr = ad; bus.wdata = wd;
    cur_rst = rst;
    dec = '0; exp_gnt = '0;
    if (rst && en) begin
      if (ps == SLOT) begin
        dec.ram_en = 1; dec.vga = 1;
        dec.raddr = RAW'(int'(vga_addr) + VBASE);
        dec.data = shadow[dec.raddr[6:0]];
      end else begin
        for (int i = 1; i <= NP; i++) begin
          int p; logic [AW-1:0] a;
          p = (ptr + i) % NP;
          a = ad[p*AW +: AW];
          if (exp_gnt == 0 && rq[p]) begin
            exp_gnt[p] = 1'b1; dec.port = 8'(p); dec.rsp = !wv[p];
            if (a[AW-1]) begin
              dec.iow = wv[p]; dec.ior = !wv[p]; dec.ioaddr = a[AW-2:0];
              dec.iowd = wd[p*DW +: DW]; dec.data = io_fn(a[AW-2:0]);
            end else if (a < (1 << RAW)) begin
              dec.ram_en = 1; dec.ram_we = wv[p]; dec.raddr = a[RAW-1:0];
              dec.rwd = wd[p*DW +: DW]; dec.data = shadow[a[6:0]];
            end else begin
              dec.data = '0;
            end
          end
        end
      end
    end
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!cur_rst) begin
      ptr = NP - 1; s1 = '0; s2 = '0; vga_last = '0;
    end else begin
      if (dec.ram_en && dec.ram_we) shadow[dec.raddr[6:0]] = dec.rwd;
      if (exp_gnt != 0) ptr = int'(dec.port);
      if (s2.vga) vga_last = s2.data;
      s2 = s1; s1 = dec;
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(1, 1, 2'd1, '0, '0, '0, '0); tick();
    end
  endtask

  task automatic test_reset();
    drive(0, 1, 2'd1, 2'b11, 2'b00, pa(24'd0, 24'd1), '0);
    total_cnt++; if (bus.gnt !== 2'b00) $display("FAIL rst_gnt got=%b exp=00", bus.gnt); else pass_cnt++;
    tick(); preload = 1'b0;
    drive(0, 1, 2'd1, 2'b11, 2'b00, pa(24'd0, 24'd1), '0);
    total_cnt++; if ({ram_en, ram_we, io_wr, io_rd, vga_valid} !== 5'b0) $display("FAIL rst_strobes got=%b exp=0", {ram_en, ram_we, io_wr, io_rd, vga_valid}); else pass_cnt++;
    total_cnt++; if ({ram_addr, ram_wdata, io_addr, io_wdata} !== '0) $display("FAIL rst_buses got=%h exp=0", {ram_addr, ram_wdata, io_addr, io_wdata}); else pass_cnt++;
    total_cnt++; if ({bus.rvalid, bus.rdata, vga_data_out} !== '0) $display("FAIL rst_rsp got=%h exp=0", {bus.rvalid, bus.rdata, vga_data_out}); else pass_cnt++;
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 2'd1, 2'b11, 2'b00, pa(24'd0, 24'd1), '0);
      total_cnt++; if (bus.gnt !== ((k % 2 == 0) ? 2'b01 : 2'b10)) $display("FAIL first_gnt%0d got=%b exp=%b", k, bus.gnt, (k % 2 == 0) ? 2'b01 : 2'b10); else pass_cnt++;
      tick();
    end
    idle(3);
  endtask

  task automatic test_ram_roundtrip();
    drive(1, 1, 2'd1, 2'b01, 2'b01, pa(24'd10, 24'd0), {16'h0, 16'hBEEF});
    total_cnt++; if (bus.gnt !== 2'b01) $display("FAIL rt_wgnt got=%b exp=01", bus.gnt); else pass_cnt++;
    tick();
    drive(1, 1, 2'd1, 2'b01, 2'b00, pa(24'd10, 24'd0), '0);
    total_cnt++; if ({ram_en, ram_we, ram_addr, ram_wdata} !== {1'b1, 1'b1, 15'd10, 16'hBEEF}) $display("FAIL rt_wcmd got=%b/%b/%0d/%h exp=1/1/10/beef", ram_en, ram_we, ram_addr, ram_wdata); else pass_cnt++;
    total_cnt++; if (bus.gnt !== 2'b01) $display("FAIL rt_rgnt got=%b exp=01", bus.gnt); else pass_cnt++;
    tick();
    drive(1, 1, 2'd1, '0, '0, '0, '0);
    total_cnt++; if ({ram_en, ram_we, ram_addr, bus.rvalid} !== {1'b1, 1'b0, 15'd10, 2'b00}) $display("FAIL rt_rcmd got=%b/%b/%0d/%b exp=1/0/10/00", ram_en, ram_we, ram_addr, bus.rvalid); else pass_cnt++;
    tick();
    drive(1, 1, 2'd1, '0, '0, '0, '0);
    total_cnt++; if ({bus.rvalid, bus.rdata} !== {2'b01, 16'hBEEF}) $display("FAIL rt_rsp got=%b/%h exp=01/beef", bus.rvalid, bus.rdata); else pass_cnt++;
    tick();
    drive(1, 1, 2'd1, '0, '0, '0, '0);
    total_cnt++; if ({bus.rvalid, bus.rdata} !== 18'h0) $display("FAIL rt_after got=%b/%h exp=00/0000", bus.rvalid, bus.rdata); else pass_cnt++;
    tick();
  endtask

  task automatic test_io();
    drive(1, 1, 2'd1, 2'b10, 2'b10, pa(24'd0, {1'b1, 23'd19456}), {16'h0042, 16'h0});
    total_cnt++; if (bus.gnt !== 2'b10) $display("FAIL io_wgnt got=%b exp=10", bus.gnt); else pass_cnt++;
    tick();
    drive(1, 1, 2'd1, 2'b10, 2'b00, pa(24'd0, {1'b1, 23'd19968}), '0);
    total_cnt++; if ({io_wr, io_rd, ram_en, io_addr, io_wdata} !== {3'b100, 23'd19456, 16'h0042}) $display("FAIL io_wcmd got=%b%b%b/%0d/%h exp=100/19456/0042", io_wr, io_rd, ram_en, io_addr, io_wdata); else pass_cnt++;
    tick();
    drive(1, 1, 2'd1, '0, '0, '0, '0);
    total_cnt++; if ({io_wr, io_rd, ram_en, io_addr} !== {3'b010, 23'd19968}) $display("FAIL io_rcmd got=%b%b%b/%0d exp=010/19968", io_wr, io_rd, ram_en, io_addr); else pass_cnt++;
    tick();
    drive(1, 1, 2'd1, '0, '0, '0, '0);
    total_cnt++; if ({bus.rvalid, bus.rdata, io_wr, io_rd} !== {2'b10, 16'h1234, 2'b00}) $display("FAIL io_rsp got=%b/%h/%b%b exp=10/1234/00", bus.rvalid, bus.rdata, io_wr, io_rd); else pass_cnt++;
    tick();
  endtask

  task automatic test_vga();
    vga_addr = 15'd100;
    for (int k = 0; k < 5; k++) begin
      drive(1, 1, 2'(k % 4), 2'b11, 2'b00, pa(24'd5, 24'd5), '0);
      if (k == 0) begin
        total_cnt++; if (bus.gnt !== 2'b00) $display("FAIL vga_slot_gnt got=%b exp=00", bus.gnt); else pass_cnt++;
      end
      if (k == 2) begin
        total_cnt++; if ({vga_valid, vga_data_out} !== {1'b1, 16'h00FF}) $display("FAIL vga_load got=%b/%h exp=1/00ff", vga_valid, vga_data_out); else pass_cnt++;
      end
      if (k == 3) begin
        total_cnt++; if ({vga_valid, vga_data_out} !== {1'b0, 16'h00FF}) $display("FAIL vga_hold got=%b/%h exp=0/00ff", vga_valid, vga_data_out); else pass_cnt++;
      end
      tick();
    end
    idle(3);
  endtask

  task automatic test_oor_enable();
    drive(1, 1, 2'd1, 2'b01, 2'b00, pa(24'h400000, 24'd0), '0);
    total_cnt++; if (bus.gnt !== 2'b01) $display("FAIL oor_gnt got=%b exp=01", bus.gnt); else pass_cnt++;
    tick();
    drive(1, 1, 2'd1, '0, '0, '0, '0);
    total_cnt++; if ({ram_en, io_wr, io_rd} !== 3'b000) $display("FAIL oor_cmd got=%b%b%b exp=000", ram_en, io_wr, io_rd); else pass_cnt++;
    tick();
    drive(1, 1, 2'd1, '0, '0, '0, '0);
    total_cnt++; if ({bus.rvalid, bus.rdata} !== {2'b01, 16'h0}) $display("FAIL oor_rsp got=%b/%h exp=01/0000", bus.rvalid, bus.rdata); else pass_cnt++;
    tick();
    drive(1, 1, 2'd1, 2'b01, 2'b00, pa(24'd10, 24'd0), '0);
    tick();
    drive(1, 0, 2'd1, 2'b11, 2'b00, pa(24'd10, 24'd10), '0);
    total_cnt++; if ({bus.gnt, ram_en} !== 3'b001) $display("FAIL en_off1 got=%b/%b exp=00/1", bus.gnt, ram_en); else pass_cnt++;
    tick();
    drive(1, 0, 2'd0, 2'b11, 2'b00, pa(24'd10, 24'd10), '0);
    total_cnt++; if ({bus.gnt, ram_en, io_wr, io_rd} !== 5'b00000) $display("FAIL en_off2 got=%b/%b%b%b exp=00/000", bus.gnt, ram_en, io_wr, io_rd); else pass_cnt++;
    total_cnt++; if ({bus.rvalid, bus.rdata} !== {2'b01, 16'hBEEF}) $display("FAIL en_inflight got=%b/%h exp=01/beef", bus.rvalid, bus.rdata); else pass_cnt++;
    tick();
    drive(1, 0, 2'd1, 2'b11, 2'b00, pa(24'd10, 24'd10), '0);
    total_cnt++; if ({ram_en, bus.rvalid, vga_valid} !== 4'b0) $display("FAIL en_quiet got=%b/%b/%b exp=0/00/0", ram_en, bus.rvalid, vga_valid); else pass_cnt++;
    tick();
  endtask

  task automatic test_mid_reset();
    drive(1, 1, 2'd1, 2'b01, 2'b00, pa(24'd10, 24'd0), '0);
    tick();
    drive(0, 1, 2'd1, '0, '0, '0, '0);
    tick();
    drive(1, 1, 2'd1, '0, '0, '0, '0);
    total_cnt++; if ({bus.rvalid, ram_en, vga_data_out} !== '0) $display("FAIL mr_cancel got=%b/%b/%h exp=00/0/0000", bus.rvalid, ram_en, vga_data_out); else pass_cnt++;
    tick();
    drive(1, 1, 2'd1, 2'b11, 2'b00, pa(24'd0, 24'd1), '0);
    total_cnt++; if ({bus.gnt, bus.rvalid} !== 4'b0100) $display("FAIL mr_ptr got=%b/%b exp=01/00", bus.gnt, bus.rvalid); else pass_cnt++;
    tick();
    idle(3);
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      logic [NP*AW-1:0] ad; logic [NP*DW-1:0] wd;
      logic [NP-1:0] rv_exp; logic [DW-1:0] rd_exp, vd_exp;
      for (int p = 0; p < NP; p++) begin
        int k;
        k = $urandom_range(0, 9);
        if (k < 6)      ad[p*AW +: AW] = AW'($urandom_range(0, 31));
        else if (k < 9) ad[p*AW +: AW] = {1'b1, 23'($urandom)};
        else            ad[p*AW +: AW] = AW'(24'h008000 + 24'($urandom_range(0, 3)) * 24'h010000);
        wd[p*DW +: DW] = DW'($urandom);
      end
      vga_addr = VAW'($urandom_range(0, 31));
      drive($urandom_range(0, 39) != 0, $urandom_range(0, 7) != 0, 2'($urandom),
            NP'($urandom), NP'($urandom), ad, wd);
      rv_exp = s2.rsp ? (NP'(1) << s2.port) : '0;
      rd_exp = s2.rsp ? s2.data : '0;
      vd_exp = s2.vga ? s2.data : vga_last;
      total_cnt++; if (bus.gnt !== exp_gnt) $display("FAIL rnd_gnt c=%0d got=%b exp=%b", c, bus.gnt, exp_gnt); else pass_cnt++;
      total_cnt++; if (ram_en !== s1.ram_en) $display("FAIL rnd_ram_en c=%0d got=%b exp=%b", c, ram_en, s1.ram_en); else pass_cnt++;
      if (s1.ram_en) begin
        total_cnt++; if ({ram_we, ram_addr} !== {s1.ram_we, s1.raddr}) $display("FAIL rnd_ram_cmd c=%0d got=%b/%0d exp=%b/%0d", c, ram_we, ram_addr, s1.ram_we, s1.raddr); else pass_cnt++;
      end
      if (s1.ram_en && s1.ram_we) begin
        total_cnt++; if (ram_wdata !== s1.rwd) $display("FAIL rnd_ram_wdata c=%0d got=%h exp=%h", c, ram_wdata, s1.rwd); else pass_cnt++;
      end
      total_cnt++; if ({io_wr, io_rd} !== {s1.iow, s1.ior}) $display("FAIL rnd_io_strb c=%0d got=%b%b exp=%b%b", c, io_wr, io_rd, s1.iow, s1.ior); else pass_cnt++;
      if (s1.iow || s1.ior) begin
        total_cnt++; if (io_addr !== s1.ioaddr) $display("FAIL rnd_io_addr c=%0d got=%h exp=%h", c, io_addr, s1.ioaddr); else pass_cnt++;
      end
      if (s1.iow) begin
        total_cnt++; if (io_wdata !== s1.iowd) $display("FAIL rnd_io_wdata c=%0d got=%h exp=%h", c, io_wdata, s1.iowd); else pass_cnt++;
      end
      total_cnt++; if ({bus.rvalid, bus.rdata} !== {rv_exp, rd_exp}) $display("FAIL rnd_rsp c=%0d got=%b/%h exp=%b/%h", c, bus.rvalid, bus.rdata, rv_exp, rd_exp); else pass_cnt++;
      total_cnt++; if ({vga_valid, vga_data_out} !== {s2.vga, vd_exp}) $display("FAIL rnd_vga c=%0d got=%b/%h exp=%b/%h", c, vga_valid, vga_data_out, s2.vga, vd_exp); else pass_cnt++;
      tick();
    end
    idle(3);
  endtask

  initial begin
    preload = 1'b1;
    vga_addr = 15'd100;
    ptr = NP - 1; s1 = '0; s2 = '0; dec = '0; vga_last = '0; cur_rst = 1'b0;
    for (int i = 0; i < 128; i++) shadow[i] = (i == 100) ? 16'h00FF : 16'h0000;
    test_reset();
    test_ram_roundtrip();
    test_io();
    test_vga();
    test_oor_enable();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
